adc_hps_pll_lock_ctrl: RTL and testbench

Reset/lock sequencer for the HPS-side ADC clock PLL (50 MHz ref, 40 MHz ADC clock). Drives the PLL's active-high reset, qualifies its asynchronous locked output, and retries on lock timeout. Publishes a debounced pll_ready and a sticky fault to the ADC capture logic and HPS CSRs. Runs entirely in the free-running reference-clock domain.

---
 rtl/adc_hps_pll_ctrl_pkg.sv | 18 +
 rtl/sync_2ff.sv | 21 ++
 rtl/adc_hps_pll_lock_ctrl.sv | 134 +++++++++++++
 tb/tb_adc_hps_pll_lock_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_hps_pll_ctrl_pkg.sv
// Shared types and default constants for the HPS ADC clock PLL reset/lock sequencer.
package adc_hps_pll_ctrl_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABILIZE,
      RUN,
      FAULT
   } pll_state_t;

   localparam int DEF_RST_HOLD_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT    = 50000;
   localparam int DEF_LOCK_STABLE     = 1024;
   localparam int DEF_MAX_RETRIES     = 3;
   localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by reset_n.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/adc_hps_pll_lock_ctrl.sv
// Reset/lock sequencer for the HPS-side ADC clock PLL: pulses pll_rst, qualifies the
// synchronized lock, retries on timeout and reports pll_ready / sticky fault.
module adc_hps_pll_lock_ctrl
   import adc_hps_pll_ctrl_pkg::*;
#(
   parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
   parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
   parameter int LOCK_STABLE     = DEF_LOCK_STABLE,
   parameter int MAX_RETRIES     = DEF_MAX_RETRIES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       soft_restart,
   output logic       pll_rst,
   output logic       pll_ready,
   output logic       fault,
   output logic [1:0] retry_cnt,
   output logic [7:0] lock_loss_cnt
);

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

   pll_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             lk;

   sync_2ff u_lock_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pll_locked),
      .q       (lk)
   );

   // Outputs are assigned on the same edge as the state they belong to, so every
   // output is a flop that is already valid in the first cycle of its state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= RESET_PLL;
         cnt           <= '0;
         pll_rst       <= 1'b1;
         pll_ready     <= 1'b0;
         fault         <= 1'b0;
         retry_cnt     <= 2'd0;
         lock_loss_cnt <= 8'd0;
      end else if (soft_restart) begin
         state     <= RESET_PLL;
         cnt       <= '0;
         pll_rst   <= 1'b1;
         pll_ready <= 1'b0;
         fault     <= 1'b0;
         retry_cnt <= 2'd0;
      end else begin
         case (state)
            RESET_PLL: begin
               pll_ready <= 1'b0;
               if (cnt == HOLD_LAST) begin
                  state   <= WAIT_LOCK;
                  cnt     <= '0;
                  pll_rst <= 1'b0;
               end else begin
                  cnt     <= cnt + 1'b1;
                  pll_rst <= 1'b1;
               end
            end

            // A lock seen in the same cycle as the timeout still counts as a lock.
            WAIT_LOCK: begin
               if (lk) begin
                  state <= STABILIZE;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt     <= '0;
                  pll_rst <= 1'b1;
                  if (retry_cnt == RETRY_LIMIT) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     state     <= RESET_PLL;
                     retry_cnt <= retry_cnt + 2'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // A dropout only restarts the lock wait; the PLL is not reset again.
            STABILIZE: begin
               if (!lk) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state     <= RUN;
                  cnt       <= '0;
                  pll_ready <= 1'b1;
                  retry_cnt <= 2'd0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RUN: begin
               if (!lk) begin
                  state     <= RESET_PLL;
                  cnt       <= '0;
                  pll_rst   <= 1'b1;
                  pll_ready <= 1'b0;
                  if (lock_loss_cnt != 8'hFF) begin
                     lock_loss_cnt <= lock_loss_cnt + 8'd1;
                  end
               end
            end

            FAULT: begin
               pll_rst   <= 1'b1;
               pll_ready <= 1'b0;
               fault     <= 1'b1;
            end

            default: begin
               state     <= RESET_PLL;
               cnt       <= '0;
               pll_rst   <= 1'b1;
               pll_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_hps_pll_lock_ctrl.sv
// Directed bench for adc_hps_pll_lock_ctrl with short hold/timeout/stable windows.
module tb_adc_hps_pll_lock_ctrl;

   localparam int RST_HOLD    = 4;
   localparam int TIMEOUT     = 20;
   localparam int STABLE      = 8;
   localparam int MAX_RETRIES = 2;
   // Two synchronizer flops plus the edge on which the FSM acts on lk.
   localparam int SYNC_LAT    = 3;
   localparam int READY_LAT   = SYNC_LAT + STABLE;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       soft_restart = 1'b0;
   logic       pll_rst;
   logic       pll_ready;
   logic       fault;
   logic [1:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   int checks = 0;
   int errors = 0;

   adc_hps_pll_lock_ctrl #(
      .RST_HOLD_CYCLES (RST_HOLD),
      .LOCK_TIMEOUT    (TIMEOUT),
      .LOCK_STABLE     (STABLE),
      .MAX_RETRIES     (MAX_RETRIES),
      .CNT_W           (16)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pll_locked    (pll_locked),
      .soft_restart  (soft_restart),
      .pll_rst       (pll_rst),
      .pll_ready     (pll_ready),
      .fault         (fault),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Holds reset for two cycles and releases it on a falling edge.
   task automatic do_reset();
      reset_n      = 1'b0;
      pll_locked   = 1'b0;
      soft_restart = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Number of falling edges for which pll_rst keeps its current level.
   task automatic measure_level(output int n);
      logic lvl;
      lvl = pll_rst;
      n = 0;
      while (pll_rst === lvl && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Falling edges until pll_ready reaches the given level (bounded).
   task automatic wait_ready(input logic level, input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pll_ready !== level && n < limit);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (pll_rst !== 1'b1 || pll_ready !== 1'b0 || fault !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got rst=%b ready=%b fault=%b expected 1 0 0",
                  pll_rst, pll_ready, fault);
      end
      checks++;
      if (retry_cnt !== 2'd0 || lock_loss_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_counts: got retry=%0d loss=%0d expected 0 0",
                  retry_cnt, lock_loss_cnt);
      end
   endtask

   task automatic test_nominal();
      int n;
      do_reset();
      measure_level(n);
      checks++;
      if (n !== RST_HOLD) begin
         errors++;
         $display("[TB] FAIL nominal_rst_width: got %0d expected %0d", n, RST_HOLD);
      end
      repeat (10) @(negedge clk);
      pll_locked = 1'b1;
      wait_ready(1'b1, 100, n);
      checks++;
      if (n !== READY_LAT) begin
         errors++;
         $display("[TB] FAIL nominal_ready_latency: got %0d expected %0d", n, READY_LAT);
      end
      checks++;
      if (retry_cnt !== 2'd0 || fault !== 1'b0 || pll_rst !== 1'b0) begin
         errors++;
         $display("[TB] FAIL nominal_status: got retry=%0d fault=%b rst=%b expected 0 0 0",
                  retry_cnt, fault, pll_rst);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      for (int a = 0; a <= MAX_RETRIES; a++) begin
         measure_level(n);
         checks++;
         if (n !== RST_HOLD) begin
            errors++;
            $display("[TB] FAIL timeout_rst_width[%0d]: got %0d expected %0d", a, n, RST_HOLD);
         end
         checks++;
         if (retry_cnt !== 2'(a)) begin
            errors++;
            $display("[TB] FAIL timeout_retry[%0d]: got %0d expected %0d", a, retry_cnt, a);
         end
         measure_level(n);
         checks++;
         if (n !== TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_window[%0d]: got %0d expected %0d", a, n, TIMEOUT);
         end
      end
      checks++;
      if (fault !== 1'b1 || pll_rst !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_fault_entry: got fault=%b rst=%b expected 1 1", fault, pll_rst);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (fault !== 1'b1 || pll_rst !== 1'b1 || pll_ready !== 1'b0 || retry_cnt !== 2'(MAX_RETRIES)) begin
         errors++;
         $display("[TB] FAIL timeout_fault_held: got fault=%b rst=%b ready=%b retry=%0d expected 1 1 0 %0d",
                  fault, pll_rst, pll_ready, retry_cnt, MAX_RETRIES);
      end
   endtask

   // Starts from FAULT as left by test_timeout.
   task automatic test_soft_restart();
      int n;
      soft_restart = 1'b1;
      @(negedge clk);
      soft_restart = 1'b0;
      checks++;
      if (fault !== 1'b0 || retry_cnt !== 2'd0 || pll_rst !== 1'b1) begin
         errors++;
         $display("[TB] FAIL soft_from_fault: got fault=%b retry=%0d rst=%b expected 0 0 1",
                  fault, retry_cnt, pll_rst);
      end
      measure_level(n);
      checks++;
      if (n !== RST_HOLD) begin
         errors++;
         $display("[TB] FAIL soft_rst_width: got %0d expected %0d", n, RST_HOLD);
      end
      measure_level(n);
      checks++;
      if (n !== TIMEOUT || retry_cnt !== 2'd1) begin
         errors++;
         $display("[TB] FAIL soft_first_timeout: got window=%0d retry=%0d expected %0d 1",
                  n, retry_cnt, TIMEOUT);
      end
      measure_level(n);
      repeat (5) @(negedge clk);
      checks++;
      if (pll_rst !== 1'b0) begin
         errors++;
         $display("[TB] FAIL soft_in_wait_lock: got rst=%b expected 0", pll_rst);
      end
      soft_restart = 1'b1;
      @(negedge clk);
      soft_restart = 1'b0;
      checks++;
      if (pll_rst !== 1'b1 || retry_cnt !== 2'd0) begin
         errors++;
         $display("[TB] FAIL soft_mid_wait: got rst=%b retry=%0d expected 1 0", pll_rst, retry_cnt);
      end
      measure_level(n);
      checks++;
      if (n !== RST_HOLD) begin
         errors++;
         $display("[TB] FAIL soft_mid_wait_width: got %0d expected %0d", n, RST_HOLD);
      end
   endtask

   task automatic test_glitch();
      int n;
      int rst_seen;
      do_reset();
      measure_level(n);
      pll_locked = 1'b1;
      // Seven edges: three to reach STABILIZE, then a few stable cycles.
      repeat (7) @(negedge clk);
      checks++;
      if (pll_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL glitch_early_ready: got %b expected 0", pll_ready);
      end
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      n = 0;
      rst_seen = 0;
      do begin
         @(negedge clk);
         n++;
         if (pll_rst !== 1'b0) rst_seen++;
      end while (pll_ready !== 1'b1 && n < 100);
      checks++;
      if (n !== READY_LAT) begin
         errors++;
         $display("[TB] FAIL glitch_ready_latency: got %0d expected %0d", n, READY_LAT);
      end
      checks++;
      if (rst_seen !== 0 || retry_cnt !== 2'd0) begin
         errors++;
         $display("[TB] FAIL glitch_no_reset: got rst_cycles=%0d retry=%0d expected 0 0",
                  rst_seen, retry_cnt);
      end
   endtask

   // Starts in RUN as left by test_glitch.
   task automatic test_run_loss();
      int n;
      int m;
      pll_locked = 1'b0;
      wait_ready(1'b0, 50, n);
      checks++;
      if (n !== SYNC_LAT) begin
         errors++;
         $display("[TB] FAIL loss_ready_fall: got %0d expected %0d", n, SYNC_LAT);
      end
      checks++;
      if (pll_rst !== 1'b1 || lock_loss_cnt !== 8'd1 || retry_cnt !== 2'd0) begin
         errors++;
         $display("[TB] FAIL loss_status: got rst=%b loss=%0d retry=%0d expected 1 1 0",
                  pll_rst, lock_loss_cnt, retry_cnt);
      end
      measure_level(n);
      checks++;
      if (n !== RST_HOLD) begin
         errors++;
         $display("[TB] FAIL loss_rst_width: got %0d expected %0d", n, RST_HOLD);
      end
      pll_locked = 1'b1;
      wait_ready(1'b1, 100, n);
      checks++;
      if (n !== READY_LAT) begin
         errors++;
         $display("[TB] FAIL loss_relock_latency: got %0d expected %0d", n, READY_LAT);
      end
      for (int i = 0; i < 259; i++) begin
         pll_locked = 1'b0;
         wait_ready(1'b0, 50, n);
         pll_locked = 1'b1;
         wait_ready(1'b1, 100, m);
         if (n >= 50 || m >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL loss_loop_timeout[%0d]: got fall=%0d rise=%0d expected <50 <100", i, n, m);
            break;
         end
      end
      checks++;
      if (lock_loss_cnt !== 8'd255) begin
         errors++;
         $display("[TB] FAIL loss_saturate: got %0d expected 255", lock_loss_cnt);
      end
   endtask

   // Starts in RUN with a saturated lock_loss_cnt.
   task automatic test_async_reset();
      int n;
      pll_locked = 1'b0;
      wait_ready(1'b0, 50, n);
      pll_locked = 1'b1;
      n = 0;
      while (pll_rst !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      checks++;
      if (pll_rst !== 1'b0 || pll_ready !== 1'b0 || lock_loss_cnt !== 8'd255) begin
         errors++;
         $display("[TB] FAIL async_pre_state: got rst=%b ready=%b loss=%0d expected 0 0 255",
                  pll_rst, pll_ready, lock_loss_cnt);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (pll_rst !== 1'b1 || pll_ready !== 1'b0 || fault !== 1'b0 ||
          retry_cnt !== 2'd0 || lock_loss_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got rst=%b ready=%b fault=%b retry=%0d loss=%0d expected 1 0 0 0 0",
                  pll_rst, pll_ready, fault, retry_cnt, lock_loss_cnt);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_timeout();
      test_soft_restart();
      test_glitch();
      test_run_loss();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
